// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types for the privileged trap/return redirect logic.
package machine_mode_types_1_12_pkg;

    // Redirect controller states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_CLEAR = 2'd1,
        ST_REDIRECT   = 2'd2
    } redirect_state_e;

    // xtvec[1:0] mode field; encodings 2 and 3 behave as direct.
    typedef enum logic [1:0] {
        TVEC_DIRECT   = 2'd0,
        TVEC_VECTORED = 2'd1
    } tvec_mode_e;

    // Kind of control transfer being served.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_TRAP = 2'd1,
        REQ_MRET = 2'd2,
        REQ_SRET = 2'd3
    } req_kind_e;

    // Context captured when a request is accepted.
    typedef struct packed {
        req_kind_e kind;
        logic      to_s;
    } redirect_ctx_t;

    // True only for the vectored encoding of the tvec mode field.
    function automatic logic is_vectored(input logic [1:0] mode);
        return mode == TVEC_VECTORED;
    endfunction

endpackage

// File: rtl/priv_1_12_tvec_calc.sv
// Combinational redirect target computation for traps, mret and sret.
module priv_1_12_tvec_calc
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SUPPORT_S = 1,
    parameter int NUM_VEC   = 16,
    parameter int CAUSE_W   = 5
) (
    input  req_kind_e         kind,
    input  logic              trap_is_intr,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic              trap_to_s,
    input  logic [XLEN-1:0]   mtvec,
    input  logic [XLEN-1:0]   stvec,
    input  logic [XLEN-1:0]   mepc,
    input  logic [XLEN-1:0]   sepc,
    output logic [XLEN-1:0]   target,
    output logic              to_s
);

    // Clears the two low bits (tvec mode field / epc misalignment).
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic            use_s_tvec;
    logic            cause_in_range;
    logic [XLEN-1:0] tvec_sel;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] vec_offset;

    assign use_s_tvec     = (SUPPORT_S != 0) && trap_to_s;
    assign tvec_sel       = use_s_tvec ? stvec : mtvec;
    assign tvec_base      = tvec_sel & ALIGN_MASK;
    assign cause_in_range = 32'(trap_cause) < 32'(NUM_VEC);
    // Sum is XLEN wide, so a base near the top of memory wraps around.
    assign vec_offset     = XLEN'(trap_cause) << 2;

    // Select the target address and privilege qualifier for the request kind.
    always_comb begin
        target = '0;
        to_s   = 1'b0;
        case (kind)
            REQ_TRAP: begin
                to_s = use_s_tvec;
                if (is_vectored(tvec_sel[1:0]) && trap_is_intr && cause_in_range) begin
                    target = tvec_base + vec_offset;
                end else begin
                    target = tvec_base;
                end
            end
            REQ_MRET: begin
                target = mepc & ALIGN_MASK;
            end
            REQ_SRET: begin
                target = sepc & ALIGN_MASK;
                to_s   = 1'b1;
            end
            default: begin
                target = '0;
            end
        endcase
    end

endmodule

// File: rtl/priv_1_12_trap_redirect_ctrl.sv
// Sequences trap entry and mret/sret redirects into the fetch stage:
// accepts one request, waits for the pipeline to drain, then holds the
// redirect until fetch acknowledges it.
module priv_1_12_trap_redirect_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SUPPORT_S = 1,
    parameter int NUM_VEC   = 16,
    parameter int CAUSE_W   = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               trap_req,
    input  logic               trap_is_intr,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic               trap_to_s,
    input  logic               mret,
    input  logic               sret,
    input  logic               pipe_clear,
    input  logic               fetch_ack,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    stvec,
    input  logic [XLEN-1:0]    mepc,
    input  logic [XLEN-1:0]    sepc,
    output logic               insert_pc,
    output logic [XLEN-1:0]    priv_pc,
    output logic               redirect_busy,
    output logic               trap_commit,
    output logic               ret_commit,
    output logic               commit_to_s
);

    redirect_state_e state_reg, state_next;
    redirect_ctx_t   ctx_reg, ctx_next;
    logic [XLEN-1:0] target_reg, target_next;
    logic            insert_pc_reg;
    logic [XLEN-1:0] priv_pc_reg;

    req_kind_e       req_kind;
    logic            accept;
    logic [XLEN-1:0] calc_target;
    logic            calc_to_s;

    priv_1_12_tvec_calc #(
        .XLEN      (XLEN),
        .SUPPORT_S (SUPPORT_S),
        .NUM_VEC   (NUM_VEC),
        .CAUSE_W   (CAUSE_W)
    ) u_tvec_calc (
        .kind         (req_kind),
        .trap_is_intr (trap_is_intr),
        .trap_cause   (trap_cause),
        .trap_to_s    (trap_to_s),
        .mtvec        (mtvec),
        .stvec        (stvec),
        .mepc         (mepc),
        .sepc         (sepc),
        .target       (calc_target),
        .to_s         (calc_to_s)
    );

    // Arbitrate pending requests: trap beats mret beats sret.
    always_comb begin
        req_kind = REQ_NONE;
        if (trap_req) begin
            req_kind = REQ_TRAP;
        end else if (mret) begin
            req_kind = REQ_MRET;
        end else if (sret && (SUPPORT_S != 0)) begin
            req_kind = REQ_SRET;
        end
    end

    // Gated by nRST so no commit pulse escapes while reset is held.
    assign accept = (state_reg == ST_IDLE) && nRST && (req_kind != REQ_NONE);

    // Next-state logic; the target and context are captured on accept.
    always_comb begin
        state_next  = state_reg;
        ctx_next    = ctx_reg;
        target_next = target_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    target_next   = calc_target;
                    ctx_next.kind = req_kind;
                    ctx_next.to_s = calc_to_s;
                    state_next    = pipe_clear ? ST_REDIRECT : ST_WAIT_CLEAR;
                end
            end
            ST_WAIT_CLEAR: begin
                if (pipe_clear) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (fetch_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, context and registered redirect outputs; priv_pc is zero unless redirecting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= ST_IDLE;
            ctx_reg       <= '{kind: REQ_NONE, to_s: 1'b0};
            target_reg    <= '0;
            insert_pc_reg <= 1'b0;
            priv_pc_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ctx_reg       <= ctx_next;
            target_reg    <= target_next;
            insert_pc_reg <= (state_next == ST_REDIRECT);
            priv_pc_reg   <= (state_next == ST_REDIRECT) ? target_next : '0;
        end
    end

    assign insert_pc     = insert_pc_reg;
    assign priv_pc       = priv_pc_reg;
    assign redirect_busy = (state_reg != ST_IDLE);
    assign trap_commit   = accept && (req_kind == REQ_TRAP);
    assign ret_commit    = accept && ((req_kind == REQ_MRET) || (req_kind == REQ_SRET));
    assign commit_to_s   = accept && calc_to_s;

endmodule

// File: tb/tb_priv_1_12_trap_redirect_ctrl.sv
// Self-checking bench: one S-capable and one M-only instance share stimulus,
// each checked cycle by cycle against a transaction-level reference model.
module tb_priv_1_12_trap_redirect_ctrl;

    localparam int XLEN    = 32;
    localparam int CAUSE_W = 5;
    localparam int NUM_VEC = 16;

    typedef struct {
        bit          tr;
        bit          intr;
        bit          to_s;
        bit          mr;
        bit          sr;
        int          cause;
        logic [31:0] mtv;
        logic [31:0] stv;
        logic [31:0] mep;
        logic [31:0] sep;
        int          d;
        int          a;
        bit          hold;
        int          rst_at;
    } txn_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               trap_req, trap_is_intr, trap_to_s, mret, sret;
    logic [CAUSE_W-1:0] trap_cause;
    logic               pipe_clear, fetch_ack;
    logic [XLEN-1:0]    mtvec, stvec, mepc, sepc;

    logic               s_insert, s_busy, s_tc, s_rc, s_cs;
    logic [XLEN-1:0]    s_pc;
    logic               m_insert, m_busy, m_tc, m_rc, m_cs;
    logic [XLEN-1:0]    m_pc;

    int n_checks = 0;
    int n_fail   = 0;

    priv_1_12_trap_redirect_ctrl #(
        .XLEN(XLEN), .SUPPORT_S(1), .NUM_VEC(NUM_VEC), .CAUSE_W(CAUSE_W)
    ) dut_s (
        .CLK(clk), .nRST(rst_n), .trap_req(trap_req), .trap_is_intr(trap_is_intr),
        .trap_cause(trap_cause), .trap_to_s(trap_to_s), .mret(mret), .sret(sret),
        .pipe_clear(pipe_clear), .fetch_ack(fetch_ack), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .insert_pc(s_insert), .priv_pc(s_pc),
        .redirect_busy(s_busy), .trap_commit(s_tc), .ret_commit(s_rc), .commit_to_s(s_cs)
    );

    priv_1_12_trap_redirect_ctrl #(
        .XLEN(XLEN), .SUPPORT_S(0), .NUM_VEC(NUM_VEC), .CAUSE_W(CAUSE_W)
    ) dut_m (
        .CLK(clk), .nRST(rst_n), .trap_req(trap_req), .trap_is_intr(trap_is_intr),
        .trap_cause(trap_cause), .trap_to_s(trap_to_s), .mret(mret), .sret(sret),
        .pipe_clear(pipe_clear), .fetch_ack(fetch_ack), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .insert_pc(m_insert), .priv_pc(m_pc),
        .redirect_busy(m_busy), .trap_commit(m_tc), .ret_commit(m_rc), .commit_to_s(m_cs)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---- reference model (instance 0 supports S-mode, instance 1 does not) ----
    function automatic int model_kind(input bit sup, input txn_t t);
        if (t.tr) return 1;
        if (t.mr) return 2;
        if (t.sr && sup) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] model_target(input bit sup, input txn_t t);
        longint unsigned tv, addr;
        case (model_kind(sup, t))
            1: begin
                tv   = (t.to_s && sup) ? longint'(t.stv) : longint'(t.mtv);
                addr = tv - (tv % 4);
                if ((tv % 4) == 1 && t.intr && t.cause < NUM_VEC) addr = addr + t.cause * 4;
                return addr[31:0];
            end
            2: return t.mep - (t.mep % 4);
            3: return t.sep - (t.sep % 4);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_to_s(input bit sup, input txn_t t);
        case (model_kind(sup, t))
            1: return t.to_s && sup;
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_inst(input int i, input string ph, input bit eb, input bit ei,
                              input logic [31:0] ep, input bit etc, input bit erc, input bit es);
        logic b, in, tc, rc, cs;
        logic [31:0] pc;
        if (i == 0) begin
            b = s_busy; in = s_insert; pc = s_pc; tc = s_tc; rc = s_rc; cs = s_cs;
        end else begin
            b = m_busy; in = m_insert; pc = m_pc; tc = m_tc; rc = m_rc; cs = m_cs;
        end
        check_val($sformatf("%s.inst%0d.redirect_busy", ph, i), b, eb);
        check_val($sformatf("%s.inst%0d.insert_pc", ph, i), in, ei);
        check_val($sformatf("%s.inst%0d.priv_pc", ph, i), pc, ep);
        check_val($sformatf("%s.inst%0d.trap_commit", ph, i), tc, etc);
        check_val($sformatf("%s.inst%0d.ret_commit", ph, i), rc, erc);
        check_val($sformatf("%s.inst%0d.commit_to_s", ph, i), cs, es);
    endtask

    function automatic txn_t new_txn();
        txn_t t;
        t.tr = 0; t.intr = 0; t.to_s = 0; t.mr = 0; t.sr = 0; t.cause = 0;
        t.mtv = 0; t.stv = 0; t.mep = 0; t.sep = 0;
        t.d = 0; t.a = 0; t.hold = 0; t.rst_at = -1;
        return t;
    endfunction

    // Runs one request from the accept cycle to the redirect acknowledge.
    // Called just after a rising edge with both instances idle.
    task automatic run_txn(input string name, input txn_t t);
        int          k [2];
        logic [31:0] tg [2];
        bit          ts [2];
        for (int i = 0; i < 2; i++) begin
            k[i]  = model_kind(i == 0, t);
            tg[i] = model_target(i == 0, t);
            ts[i] = model_to_s(i == 0, t);
        end
        trap_req = t.tr; trap_is_intr = t.intr; trap_cause = CAUSE_W'(t.cause);
        trap_to_s = t.to_s; mret = t.mr; sret = t.sr;
        mtvec = t.mtv; stvec = t.stv; mepc = t.mep; sepc = t.sep;
        pipe_clear = (t.d == 0);
        fetch_ack  = 1'($urandom_range(1));
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check_inst(i, {name, ".accept"}, 0, 0, 0, k[i] == 1, k[i] >= 2, ts[i]);
        @(posedge clk); #1;
        trap_req = t.hold; mret = 0; sret = 0;
        for (int w = 1; w <= t.d; w++) begin
            pipe_clear = (w == t.d);
            fetch_ack  = 1'($urandom_range(1));
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check_inst(i, {name, ".wait"}, k[i] != 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        pipe_clear = 1'($urandom_range(1));
        for (int r = 0; r <= t.a; r++) begin
            fetch_ack = (r == t.a);
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check_inst(i, {name, ".redirect"}, k[i] != 0, k[i] != 0,
                           (k[i] != 0) ? tg[i] : 32'h0, 0, 0, 0);
            if (r == t.rst_at) begin
                rst_n = 0; trap_req = 0; #1;
                for (int i = 0; i < 2; i++)
                    check_inst(i, {name, ".abort"}, 0, 0, 0, 0, 0, 0);
                @(posedge clk); #1;
                rst_n = 1; fetch_ack = 0;
                return;
            end
            @(posedge clk); #1;
        end
        fetch_ack = 0;
    endtask

    task automatic idle_check(input string name, input int n);
        trap_req = 0; mret = 0; sret = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) check_inst(i, name, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        txn_t t;
        rst_n = 0; trap_req = 0; trap_is_intr = 0; trap_cause = '0; trap_to_s = 0;
        mret = 0; sret = 0; pipe_clear = 0; fetch_ack = 0;
        mtvec = '0; stvec = '0; mepc = '0; sepc = '0;
        repeat (2) @(posedge clk); #1;

        // Request held during reset: no output activity.
        trap_req = 1; mtvec = 32'h0000_0100;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_inst(i, "in_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        t = new_txn(); t.tr = 1; t.mtv = 32'h0000_0100;
        run_txn("post_reset", t);

        t = new_txn(); t.tr = 1; t.intr = 1; t.cause = 7; t.mtv = 32'h0000_1001; t.a = 3;
        run_txn("vec_intr", t);
        t = new_txn(); t.tr = 1; t.intr = 0; t.cause = 2; t.mtv = 32'h0000_1001;
        run_txn("vec_exc", t);
        t = new_txn(); t.tr = 1; t.intr = 1; t.cause = 20; t.mtv = 32'h0000_1001; t.a = 1;
        run_txn("high_cause", t);

        // mret with delayed clear; a trap raised mid-wait waits for IDLE.
        t = new_txn(); t.mr = 1; t.mep = 32'h8000_0042; t.d = 4; t.a = 1; t.hold = 1;
        run_txn("mret_wait", t);
        t = new_txn(); t.tr = 1; t.intr = 1; t.cause = 5; t.mtv = 32'h0000_1001;
        run_txn("held_trap", t);

        t = new_txn(); t.tr = 1; t.to_s = 1; t.stv = 32'h0000_2000; t.mtv = 32'h0000_3000;
        run_txn("deleg", t);
        t = new_txn(); t.sr = 1; t.sep = 32'h0000_4006; t.d = 2; t.a = 1;
        run_txn("sret", t);
        t = new_txn(); t.tr = 1; t.intr = 1; t.cause = 3; t.mtv = 32'hFFFF_FFFD;
        run_txn("wrap", t);
        t = new_txn(); t.tr = 1; t.mr = 1; t.mep = 32'h0000_5000; t.mtv = 32'h0000_0600; t.d = 1;
        run_txn("trap_and_mret", t);

        // Reset during redirect aborts it and nothing is reissued.
        t = new_txn(); t.tr = 1; t.mtv = 32'h0000_0700; t.d = 1; t.a = 3; t.rst_at = 1;
        run_txn("mid_reset", t);
        idle_check("after_abort", 3);

        for (int n = 0; n < 40; n++) begin
            t = new_txn();
            t.tr = 1'($urandom_range(1)); t.mr = 1'($urandom_range(1)); t.sr = 1'($urandom_range(1));
            t.intr = 1'($urandom_range(1)); t.to_s = 1'($urandom_range(1));
            t.cause = int'($urandom_range(31));
            t.mtv = $urandom; t.stv = $urandom; t.mep = $urandom; t.sep = $urandom;
            if ($urandom_range(1) == 1) t.mtv[1:0] = 2'b01;
            if ($urandom_range(1) == 1) t.stv[1:0] = 2'b01;
            t.d = int'($urandom_range(3)); t.a = int'($urandom_range(3));
            run_txn($sformatf("rand%0d", n), t);
        end
        idle_check("final_idle", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
